// File: rtl/rle_pkg.sv
// Shared definitions for the RLE decompression controller: FSM states,
// RLE code field positions and default widths.
package rle_pkg;

    localparam int WORD_W_DEF     = 16;
    localparam int FRAME_BITS_DEF = 256;

    // in_data layout: [VAL_BIT] bit value, [RUN_MSB:0] run length
    localparam int VAL_BIT = 7;
    localparam int RUN_MSB = 6;
    localparam int RUN_W   = RUN_MSB + 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXPAND,
        EMIT,
        DONE
    } state_t;

endpackage

// File: rtl/rle_run_unit.sv
// Run/value holding register for one RLE code: loads a code, counts the
// run down one bit per expansion cycle and presents the bit value.
module rle_run_unit
    import rle_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [7:0]       code,
    input  logic             dec,
    output logic [RUN_W-1:0] run,
    output logic             bit_val
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run     <= '0;
            bit_val <= 1'b0;
        end else if (clear) begin
            run     <= '0;
            bit_val <= 1'b0;
        end else if (load) begin
            run     <= code[RUN_MSB:0];
            bit_val <= code[VAL_BIT];
        end else if (dec && run != '0) begin
            run     <= run - RUN_W'(1);
        end
    end

endmodule

// File: rtl/rle_decomp_ctrl.sv
// RLE frame decompressor: expands (value, run) codes into WORD_W-bit words.
// Define RLE_DECOMP_CTRL_STATS_EN to add the byte_cnt accepted-byte counter.
//
//   state  | meaning
//   IDLE   | waiting for start
//   FETCH  | in_ready high, waiting for the next RLE code
//   EXPAND | writing one bit per cycle into the word buffer
//   EMIT   | full word presented, waiting for out_ready
//   DONE   | one-cycle done pulse, flag residual run as overrun
module rle_decomp_ctrl
    import rle_pkg::*;
#(
    parameter int WORD_W     = WORD_W_DEF,
    parameter int FRAME_BITS = FRAME_BITS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] out_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_idx,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef RLE_DECOMP_CTRL_STATS_EN
    ,
    output logic [15:0]       byte_cnt
`endif
);

    localparam int PTR_W = $clog2(WORD_W);
    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

    state_t             state, nxt;
    logic [PTR_W-1:0]   bit_ptr;
    logic [CNT_W-1:0]   frame_cnt;
    logic [RUN_W-1:0]   run;
    logic               bit_val;
    logic               run_clr, run_load, run_dec;
    logic [PTR_W-1:0]   wr_pos;

    rle_run_unit u_run (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (run_clr),
        .load    (run_load),
        .code    (in_data),
        .dec     (run_dec),
        .run     (run),
        .bit_val (bit_val)
    );

    assign in_ready  = (state == FETCH);
    assign out_valid = (state == EMIT);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign wr_pos    = PTR_LAST - bit_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt      = state;
        run_clr  = 1'b0;
        run_load = 1'b0;
        run_dec  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    nxt     = FETCH;
                    run_clr = 1'b1;
                end
            end
            FETCH: begin
                if (in_valid) begin
                    run_load = 1'b1;
                    if (in_data[RUN_MSB:0] != '0) nxt = EXPAND;
                end
            end
            EXPAND: begin
                run_dec = 1'b1;
                // A completed word takes priority over an exhausted run
                if (bit_ptr == PTR_LAST)     nxt = EMIT;
                else if (run == RUN_W'(1))   nxt = FETCH;
            end
            EMIT: begin
                if (out_ready) begin
                    if (frame_cnt == CNT_FULL) nxt = DONE;
                    else if (run != '0)        nxt = EXPAND;
                    else                       nxt = FETCH;
                end
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_word  <= '0;
            bit_ptr   <= '0;
            frame_cnt <= '0;
            out_idx   <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        out_word  <= '0;
                        bit_ptr   <= '0;
                        frame_cnt <= '0;
                        out_idx   <= '0;
                        err       <= 1'b0;
                    end
                end
                EXPAND: begin
                    out_word[wr_pos] <= bit_val;
                    bit_ptr   <= (bit_ptr == PTR_LAST) ? '0 : bit_ptr + PTR_W'(1);
                    frame_cnt <= frame_cnt + CNT_W'(1);
                end
                EMIT: begin
                    if (out_ready) begin
                        out_word <= '0;
                        out_idx  <= out_idx + 32'd1;
                    end
                end
                DONE: begin
                    if (run != '0) err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef RLE_DECOMP_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
        end else if (state == IDLE && start) begin
            byte_cnt <= '0;
        end else if (run_load && byte_cnt != 16'hFFFF) begin
            byte_cnt <= byte_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rle_decomp_ctrl.sv
// Randomized self-checking bench for rle_decomp_ctrl against a bit-queue
// reference model of the RLE frame expansion.
module tb_rle_decomp_ctrl;
    import rle_pkg::*;

    localparam int WW = 16;
    localparam int FB = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [WW-1:0] out_word;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_idx;
    logic        busy, done, err;
`ifdef RLE_DECOMP_CTRL_STATS_EN
    logic [15:0] byte_cnt;
`endif

    rle_decomp_ctrl #(.WORD_W(WW), .FRAME_BITS(FB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_word  (out_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done),
        .err       (err)
`ifdef RLE_DECOMP_CTRL_STATS_EN
        ,
        .byte_cnt  (byte_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // results of the most recent run_frame
    logic [WW-1:0] got_word[$];
    int            got_idx[$];
    int            done_cnt, consumed, flag_bad, stall_bad, lat;
    logic          got_err, err_at_start, busy_after, done_after;
    bit            timed_out;

    // expected results from the model
    logic [WW-1:0] exp_word[$];
    bit            exp_err;
    int            exp_n;

    task automatic model_frame(input logic [7:0] src[$]);
        int bits = 0;
        logic [WW-1:0] cur = '0;
        logic [7:0] b;
        exp_word.delete();
        exp_err = 0;
        exp_n = 0;
        foreach (src[i]) begin
            if (bits >= FB) break;
            b = src[i];
            exp_n++;
            for (int k = 0; k < int'(b[6:0]); k++) begin
                if (bits == FB) begin exp_err = 1; break; end
                cur[WW - 1 - (bits % WW)] = b[7];
                bits++;
                if (bits % WW == 0) begin exp_word.push_back(cur); cur = '0; end
            end
        end
    endtask

    task automatic gen_stream(output logic [7:0] s[$]);
        int total = 0;
        logic [7:0] b;
        s.delete();
        while (total < FB) begin
            b = 8'($urandom);
            if ($urandom_range(0, 1) == 1) b[6:0] = 7'($urandom_range(0, 20));
            if ($urandom_range(0, 7) == 0) b[6:0] = 7'd0;
            s.push_back(b);
            total += int'(b[6:0]);
        end
        for (int i = 0; i < int'($urandom_range(0, 2)); i++) s.push_back(8'($urandom));
    endtask

    // mode 0: always ready; 1: random valid/ready gaps; 2: stall first word 10 cycles
    task automatic run_frame(input logic [7:0] src_in[$], input int mode);
        logic [7:0] src[$];
        int cyc = 0, acc_cyc = -1, first_ov = -1, stall_left;
        logic [WW-1:0] hold_w = '0;
        logic [31:0]   hold_i = '0;
        src = src_in;
        got_word.delete(); got_idx.delete();
        done_cnt = 0; consumed = 0; flag_bad = 0; stall_bad = 0; timed_out = 0;
        stall_left = (mode == 2) ? 10 : 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        err_at_start = err;
        while (done_cnt == 0 && cyc < 4000) begin
            if (done) begin
                done_cnt++;
                if (in_ready) flag_bad++;
            end
            if (!busy) flag_bad++;
            in_valid = (src.size() > 0) && (mode != 1 || $urandom_range(0, 3) != 0);
            in_data  = (src.size() > 0) ? src[0] : 8'h00;
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (out_valid && stall_left > 0) begin
                if (stall_left < 10 && (out_word !== hold_w || out_idx !== hold_i)) stall_bad++;
                if (in_ready) stall_bad++;
                hold_w = out_word; hold_i = out_idx;
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (in_valid && in_ready) begin
                if (acc_cyc < 0) acc_cyc = cyc;
                void'(src.pop_front());
                consumed++;
            end
            if (out_valid && out_ready) begin
                got_word.push_back(out_word);
                got_idx.push_back(int'(out_idx));
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        timed_out = (done_cnt == 0);
        lat = first_ov - acc_cyc;
        got_err = err;
        busy_after = busy;
        done_after = done;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, busy, done, err} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 00000", {in_ready, out_valid, busy, done, err});
        end
        checks++;
        if (out_word !== '0 || out_idx !== 32'd0) begin
            errors++; $display("FAIL reset_data: got word=%h idx=%0d expected 0/0", out_word, out_idx);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_directed_fill;
        logic [7:0] s[$] = '{8'h90, 8'h70, 8'h70, 8'h70};
        model_frame(s);
        run_frame(s, 0);
        checks++;
        if (timed_out) begin errors++; $display("FAIL fill_timeout: got no done expected done"); end
        checks++;
        if (got_word.size() != 16) begin errors++; $display("FAIL fill_count: got %0d expected 16", got_word.size()); end
        checks++;
        if (got_word.size() > 0 && got_word[0] !== 16'hFFFF) begin
            errors++; $display("FAIL fill_word0: got %h expected ffff", got_word[0]);
        end
        for (int i = 0; i < got_word.size() && i < exp_word.size(); i++) begin
            checks++;
            if (got_word[i] !== exp_word[i] || got_idx[i] != i) begin
                errors++; $display("FAIL fill_word%0d: got %h idx %0d expected %h idx %0d", i, got_word[i], got_idx[i], exp_word[i], i);
            end
        end
        checks++;
        if (lat != WW + 1) begin errors++; $display("FAIL fill_latency: got %0d expected %0d", lat, WW + 1); end
        checks++;
        if (got_err !== exp_err) begin errors++; $display("FAIL fill_err: got %b expected %b", got_err, exp_err); end
        checks++;
        if (flag_bad != 0 || busy_after !== 1'b0 || done_after !== 1'b0) begin
            errors++; $display("FAIL fill_flags: got bad=%0d busy=%b done=%b expected 0/0/0", flag_bad, busy_after, done_after);
        end
        checks++;
        if (consumed != exp_n) begin errors++; $display("FAIL fill_consumed: got %0d expected %0d", consumed, exp_n); end
    endtask

    task automatic test_zero_run;
        logic [7:0] s[$];
        for (int pass = 0; pass < 3; pass++) begin
            s = '{8'h83, 8'h05, 8'h88, 8'h70, 8'h70, 8'h10};
            if (pass > 0) s.insert($urandom_range(0, 3), 8'h00);
            model_frame(s);
            run_frame(s, pass == 2 ? 1 : 0);
            checks++;
            if (got_word.size() == 0 || got_word[0] !== 16'hE0FF) begin
                errors++; $display("FAIL zero_word0: got %h expected e0ff", got_word.size() ? got_word[0] : 16'hxxxx);
            end
            checks++;
            if (got_word != exp_word || got_err !== exp_err || consumed != exp_n) begin
                errors++; $display("FAIL zero_frame: got n=%0d err=%b used=%0d expected n=%0d err=%b used=%0d",
                                   got_word.size(), got_err, consumed, exp_word.size(), exp_err, exp_n);
            end
        end
    endtask

    task automatic test_stall;
        logic [7:0] s[$];
        gen_stream(s);
        s.push_front(8'h9F);
        model_frame(s);
        run_frame(s, 2);
        checks++;
        if (stall_bad != 0) begin errors++; $display("FAIL stall_stable: got %0d violations expected 0", stall_bad); end
        checks++;
        if (got_word != exp_word || got_err !== exp_err) begin
            errors++; $display("FAIL stall_frame: got n=%0d err=%b expected n=%0d err=%b", got_word.size(), got_err, exp_word.size(), exp_err);
        end
    endtask

    task automatic test_overrun;
        logic [7:0] s[$] = '{8'hFF, 8'hFF, 8'h83};
        model_frame(s);
        run_frame(s, 0);
        checks++;
        if (got_word.size() != 16 || done_cnt != 1) begin
            errors++; $display("FAIL ovr_count: got words=%0d done=%0d expected 16/1", got_word.size(), done_cnt);
        end
        checks++;
        if (got_err !== 1'b1) begin errors++; $display("FAIL ovr_err: got %b expected 1", got_err); end
        gen_stream(s);
        model_frame(s);
        run_frame(s, 0);
        checks++;
        if (err_at_start !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", err_at_start); end
        checks++;
        if (got_word != exp_word || got_err !== exp_err) begin
            errors++; $display("FAIL ovr_next: got n=%0d err=%b expected n=%0d err=%b", got_word.size(), got_err, exp_word.size(), exp_err);
        end
    endtask

    task automatic test_random;
        logic [7:0] s[$];
        for (int f = 0; f < 8; f++) begin
            gen_stream(s);
            model_frame(s);
            run_frame(s, f % 2);
            checks++;
            if (timed_out || got_word != exp_word || got_err !== exp_err || consumed != exp_n || flag_bad != 0) begin
                errors++; $display("FAIL rand_frame%0d: got n=%0d err=%b used=%0d bad=%0d expected n=%0d err=%b used=%0d bad=0",
                                   f, got_word.size(), got_err, consumed, flag_bad, exp_word.size(), exp_err, exp_n);
            end
            for (int i = 0; i < got_idx.size(); i++) begin
                checks++;
                if (got_idx[i] != i) begin errors++; $display("FAIL rand_idx: got %0d expected %0d", got_idx[i], i); end
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] s[$];
        int n = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        in_valid = 1'b1; in_data = 8'h90;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, done, err} !== 5'b0 || out_word !== '0 || out_idx !== 32'd0) begin
            errors++; $display("FAIL midrst_out: got flags=%b word=%h idx=%0d expected 0", {in_ready, out_valid, busy, done, err}, out_word, out_idx);
        end
        @(negedge clk); rst_n = 1'b1;
        gen_stream(s);
        model_frame(s);
        run_frame(s, 0);
        checks++;
        if (got_word != exp_word || got_err !== exp_err) begin
            errors++; $display("FAIL midrst_frame: got n=%0d err=%b expected n=%0d err=%b", got_word.size(), got_err, exp_word.size(), exp_err);
        end
    endtask

`ifdef RLE_DECOMP_CTRL_STATS_EN
    task automatic test_stats;
        logic [7:0] s[$] = '{8'h83, 8'h00, 8'h05, 8'h88};
        int n = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (!out_valid && n < 100) begin
            in_valid = (s.size() > 0);
            in_data  = (s.size() > 0) ? s[0] : 8'h00;
            if (in_valid && in_ready) void'(s.pop_front());
            @(negedge clk); n++;
        end
        in_valid = 1'b0;
        checks++;
        if (byte_cnt !== 16'd4) begin errors++; $display("FAIL stats_cnt: got %0d expected 4", byte_cnt); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (byte_cnt !== 16'd0) begin errors++; $display("FAIL stats_rst: got %0d expected 0", byte_cnt); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_directed_fill();
        test_zero_run();
        test_stall();
        test_overrun();
        test_random();
        test_reset_mid();
`ifdef RLE_DECOMP_CTRL_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rle_decomp_ctrl.md
RLE_DECOMP_CTRL -- requirements
Module: rle_decomp_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 16: output word width in bits.
REQ-002 SHALL have parameter FRAME_BITS, default 256: decompressed bits per frame; a multiple of WORD_W.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: a one-cycle pulse that begins a frame.
REQ-006 SHALL have port in_data, input, 8: RLE code; bit 7 is the bit value, bits 6:0 are the run length (0..127).
REQ-007 SHALL have port in_valid, input, 1: in_data is valid.
REQ-008 SHALL have port in_ready, output, 1: the block accepts in_data this cycle.
REQ-009 SHALL have port out_word, output, WORD_W: decompressed word, MSB holds the first bit.
REQ-010 SHALL have port out_valid, output, 1: out_word is valid.
REQ-011 SHALL have port out_ready, input, 1: the sink accepts out_word.
REQ-012 SHALL have port out_idx, output, 32: index of out_word within the frame, starting at 0.
REQ-013 SHALL have port busy, output, 1: high from the start pulse until done.
REQ-014 SHALL have port done, output, 1: one-cycle pulse at end of frame.
REQ-015 SHALL have port err, output, 1: sticky overrun flag; cleared by the next start.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, EXPAND, EMIT, DONE.
REQ-017 SHALL, in IDLE, on start go to FETCH; clear out_idx, err, the word buffer and the frame bit count.
REQ-018 SHALL ignore start in any state other than IDLE.
REQ-019 SHALL drive in_ready high only in FETCH.
REQ-020 SHALL, on in_valid and in_ready, latch run and value; go to EXPAND if run > 0; stay in FETCH if run == 0 (byte consumed, no bits produced).
REQ-021 SHALL, in EXPAND, write one bit per cycle at bit position WORD_W-1-bit_ptr, then increment bit_ptr and the frame bit count and decrement run.
REQ-022 SHALL go to EMIT when bit_ptr wraps from WORD_W-1; otherwise go to FETCH when run reaches 0.
REQ-023 SHALL, in EMIT, hold out_valid high with out_word and out_idx stable until out_ready.
REQ-024 SHALL, on acceptance in EMIT, clear the buffer and increment out_idx.
REQ-025 SHALL, after acceptance in EMIT, go to DONE if the frame count equals FRAME_BITS; else go to EXPAND if run > 0; else go to FETCH.
REQ-026 SHALL, in DONE, pulse done for one cycle, set err if run > 0 (residual run discarded), and go to IDLE.
REQ-027 SHALL, when out_valid and out_ready coincide with a word completing, never lose or duplicate a word; each word is presented exactly once.
REQ-028 SHALL produce the first out_valid exactly WORD_W+1 cycles after the first accepted byte when that byte's run is >= WORD_W and no stalls occur.
REQ-029 SHALL keep busy high in FETCH, EXPAND, EMIT and DONE.
REQ-030 SHALL hold in_ready low in DONE.

Reset
REQ-031 SHALL, on rst_n low, immediately force IDLE, in_ready=0, out_valid=0, out_word=0, out_idx=0, busy=0, done=0, err=0, and clear run and bit_ptr, including mid-frame.
REQ-032 SHALL resume normal operation on the first rising clk edge after rst_n deasserts, waiting in IDLE for start.

Configuration
REQ-033 SHALL, with RLE_DECOMP_CTRL_STATS_EN defined, add output byte_cnt (16 bits) counting compressed bytes accepted in the current frame; cleared on start and reset; saturates at 0xFFFF.
REQ-034 SHALL, without RLE_DECOMP_CTRL_STATS_EN, have no byte_cnt port and no counter logic.

Structure
REQ-035 SHALL take the FSM state enum, the RLE field positions (VAL_BIT=7, RUN_MSB=6) and the default widths from shared package rle_pkg.
REQ-036 SHALL contain one sub-module, rle_run_unit, holding run/value latch, decrement and bit output; the FSM, word buffer and handshakes stay in rle_decomp_ctrl.

Verification
REQ-037 SHALL cover: start, bytes 0x90, 0x70, out_ready=1 -> words 0xFFFF idx0, 0x0000 idx1, remaining 0x0000 after 0x70 expires; 0x10 ones then 0x70 zeros fill idx1..idx7 as 0x0000, idx0=0xFFFF; done after idx15 with extra bytes 0x70,0x70 supplied.
REQ-038 SHALL cover: bytes 0x83, 0x05, 0x88 -> out_word idx0 = 0xE0FF, with a zero-run byte 0x00 inserted anywhere producing no change.
REQ-039 SHALL cover: out_ready held low 10 cycles during EMIT -> out_word and out_idx stable, in_ready low, no bit lost after release.
REQ-040 SHALL cover: a frame fed 2 x 0xFF, 0x83 (257 bits) -> 16 words, done pulse, err=1; the next start clears err.
REQ-041 SHALL cover: rst_n low mid-EXPAND -> all outputs zero the same cycle; a new frame after release is bit-exact.
REQ-042 SHALL cover, with RLE_DECOMP_CTRL_STATS_EN: the REQ-038 stream -> byte_cnt=4; 0 after reset.
